dec_to_bin_encoder: RTL and testbench

DEC_TO_BIN_ENCODER -- requirements
Module: dec_to_bin_encoder

---
 rtl/dec_to_bin_encoder_pkg.sv | 19 +
 rtl/dec_to_bin_encoder_if.sv | 26 ++
 rtl/dec_to_bin_encoder_onehot4_to_bin2.sv | 27 ++
 rtl/dec_to_bin_encoder.sv | 88 ++++++++
 tb/tb_dec_to_bin_encoder.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/dec_to_bin_encoder_pkg.sv
// Shared types for the decimal-line to binary encoder: FIFO state encoding,
// the code width, and the entry layout stored in the two-deep buffer.
package dec_to_bin_encoder_pkg;

    localparam int OH_W   = 4;
    localparam int CODE_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              err;
    } entry_t;

endpackage

// File: rtl/dec_to_bin_encoder_if.sv
// Producer/consumer channel of the encoder: decimal-line words in, binary
// codes out, each side with its own valid/ready pair.
interface dec_to_bin_encoder_if;
    import dec_to_bin_encoder_pkg::*;

    // A transfer happens on a side only in a cycle where both valid and ready
    // are high; valid must not wait on ready, and the payload travels with valid.
    logic [OH_W-1:0]   in_oh;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_err;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_oh, in_valid, out_ready,
        input  in_ready, out_code, out_err, out_valid
    );

    modport slave (
        input  in_oh, in_valid, out_ready,
        output in_ready, out_code, out_err, out_valid
    );

endinterface

// File: rtl/dec_to_bin_encoder_onehot4_to_bin2.sv
// Combinational encoder: index of the highest set line, plus a flag for any
// word that is not exactly one-hot (no line or several lines set).
module onehot4_to_bin2
    import dec_to_bin_encoder_pkg::*;
(
    input  logic [OH_W-1:0]   oh,
    output logic [CODE_W-1:0] code,
    output logic              err
);

    logic one_hot;

    always_comb begin
        code = '0;
        casez (oh)
            4'b1???: code = 2'd3;
            4'b01??: code = 2'd2;
            4'b001?: code = 2'd1;
            default: code = 2'd0;
        endcase
    end

    // Clearing the lowest set bit leaves zero only for a single-bit word.
    assign one_hot = (oh != '0) && ((oh & (oh - 4'd1)) == '0);
    assign err     = !one_hot;

endmodule

// File: rtl/dec_to_bin_encoder.sv
// Encodes decimal-line words into registered binary codes held in a two-entry
// FIFO, and counts accepted non-one-hot words in a saturating counter.
module dec_to_bin_encoder
    import dec_to_bin_encoder_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dec_to_bin_encoder_if.slave  bus,
    output logic [ERR_CNT_W-1:0] err_count,
    output state_t               state
);

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    entry_t new_entry;
    logic   push, pop;

    onehot4_to_bin2 u_enc (
        .oh   (bus.in_oh),
        .code (new_entry.code),
        .err  (new_entry.err)
    );

    // in_ready comes from state alone so it never loops back from out_ready.
    assign bus.in_ready  = !rst && (state_q != TWO);
    assign bus.out_valid = !rst && (state_q != EMPTY);
    assign bus.out_code  = head_q.code;
    assign bus.out_err   = head_q.err;
    assign state         = state_q;

    assign push = bus.in_valid  && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = new_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = new_entry;
                end else if (push) begin
                    tail_d  = new_entry;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (push && new_entry.err && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_dec_to_bin_encoder.sv
// Bench for dec_to_bin_encoder: directed scenarios then random traffic,
// compared each cycle against a queue-based reference model.
module tb_dec_to_bin_encoder;
    import dec_to_bin_encoder_pkg::*;

    logic clk;
    logic rst;
    logic [7:0] err_count8;
    logic [1:0] err_count2;
    state_t     state8;
    state_t     state2;

    dec_to_bin_encoder_if bus8 ();
    dec_to_bin_encoder_if bus2 ();

    dec_to_bin_encoder #(.ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus8),
        .err_count (err_count8),
        .state     (state8)
    );

    dec_to_bin_encoder #(.ERR_CNT_W(2)) dut_w2 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2),
        .err_count (err_count2),
        .state     (state2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: {err, code} per buffered entry, oldest first
    logic [2:0] exp_q[$];
    int         err_total;
    int         n_checks;
    int         n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [2:0] model_encode(input logic [3:0] w);
        logic [1:0] code;
        logic       err;
        code = 2'd0;
        for (int i = 0; i < 4; i++) if (w[i]) code = 2'(i);
        err = ($countones(w) != 1);
        return {err, code};
    endfunction

    task automatic check_outputs();
        logic   exp_ready, exp_valid;
        state_t exp_state;
        int     sat8, sat2;
        exp_ready = !rst && (exp_q.size() < 2);
        exp_valid = !rst && (exp_q.size() > 0);
        exp_state = (exp_q.size() == 0) ? EMPTY : (exp_q.size() == 1) ? ONE : TWO;
        sat8 = (err_total > 255) ? 255 : err_total;
        sat2 = (err_total > 3) ? 3 : err_total;
        check("in_ready",  32'(bus8.in_ready),  32'(exp_ready));
        check("out_valid", 32'(bus8.out_valid), 32'(exp_valid));
        check("state",     32'(state8),         32'(exp_state));
        check("err_count", 32'(err_count8),     32'(sat8));
        check("err_count_w2", 32'(err_count2),  32'(sat2));
        check("in_ready_w2",  32'(bus2.in_ready), 32'(exp_ready));
        if (exp_valid) begin
            check("out_code", 32'(bus8.out_code), 32'(exp_q[0][1:0]));
            check("out_err",  32'(bus8.out_err),  32'(exp_q[0][2]));
            check("out_code_w2", 32'(bus2.out_code), 32'(exp_q[0][1:0]));
        end else if (exp_q.size() == 0 && rst) begin
            check("rst_out_code", 32'(bus8.out_code), 32'd0);
            check("rst_out_err",  32'(bus8.out_err),  32'd0);
        end
    endtask

    // driver: check the settled outputs, apply one cycle of inputs, advance the model
    task automatic step(input logic r, input logic [3:0] oh, input logic v, input logic ordy);
        logic do_push, do_pop;
        @(negedge clk);
        check_outputs();
        rst = r;
        bus8.in_oh = oh;  bus8.in_valid = v;  bus8.out_ready = ordy;
        bus2.in_oh = oh;  bus2.in_valid = v;  bus2.out_ready = ordy;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            err_total = 0;
        end else begin
            do_push = v && (exp_q.size() < 2);
            do_pop  = ordy && (exp_q.size() > 0);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back(model_encode(oh));
                if (model_encode(oh)[2]) err_total++;
            end
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 1'b0, ordy);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        err_total = 0;
        rst = 1'b1;
        bus8.in_oh = '0;  bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;
        bus2.in_oh = '0;  bus2.in_valid = 1'b0;  bus2.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b1, 4'b0000, 1'b0, 1'b0);

        // single word, code 10 one cycle later
        step(1'b0, 4'b0100, 1'b1, 1'b1);
        idle(2, 1'b1);

        // zero word then two-bit word, both flagged
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        step(1'b0, 4'b1010, 1'b1, 1'b0);
        idle(3, 1'b1);

        // third push while full is dropped
        step(1'b0, 4'b0001, 1'b1, 1'b0);
        step(1'b0, 4'b0010, 1'b1, 1'b0);
        step(1'b0, 4'b1000, 1'b1, 1'b0);
        idle(3, 1'b1);

        // push and pop together while holding one entry
        step(1'b0, 4'b0001, 1'b1, 1'b0);
        step(1'b0, 4'b1000, 1'b1, 1'b1);
        step(1'b0, 4'b0000, 1'b0, 1'b0);
        idle(2, 1'b1);

        // five erroneous words: narrow counter saturates at 3
        for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, 1'b1, 1'b1);
        idle(2, 1'b1);

        // reset while full
        step(1'b0, 4'b0010, 1'b1, 1'b0);
        step(1'b0, 4'b0100, 1'b1, 1'b0);
        step(1'b1, 4'b0001, 1'b1, 1'b0);
        idle(2, 1'b0);

        // random traffic with occasional reset
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 60) == 0),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0));
        end
        idle(3, 1'b1);

        @(negedge clk);
        check_outputs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
